lcd_read_status: RTL and testbench

Nios II custom-instruction block that performs HD44780 read cycles (lcd_rw=1) on the character-LCD bus, the read-side counterpart of the LCD initialization/write block. It reads the busy flag plus address counter (RS=0) or one data-RAM byte (RS=1). It can optionally re-poll the busy flag until it clears, which gives software a reliable "LCD ready" primitive between writes. It sits between the Nios custom-instruction port and the LCD pins, sharing lcd_enable/lcd_rs/lcd_rw with the writer through top-level muxing.

---
 rtl/lcd_pkg.sv | 27 ++
 rtl/lcd_bus_timer.sv | 29 ++
 rtl/lcd_read_status.sv | 135 +++++++++++++
 tb/tb_lcd_read_status.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants for the character-LCD read and write paths: FSM state codes,
// command/result bit positions and default bus timing (50 MHz clock).
package lcd_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_EN_HIGH = 3'd2;
    localparam logic [2:0] ST_HOLD    = 3'd3;
    localparam logic [2:0] ST_CHECK   = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    localparam int LCD_BUSY_BIT       = 7;
    localparam int CMD_RS_BIT         = 0;
    localparam int CMD_POLL_BIT       = 1;
    localparam int RESULT_TIMEOUT_BIT = 31;

    localparam int LCD_T_AS = 2;
    localparam int LCD_T_PW = 12;
    localparam int LCD_T_H  = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_bus_timer.sv
// Loadable down-counter timing the LCD bus phases; expired flags the last
// counted cycle of a phase (value 1, or 0 when idle/zero-loaded).
module lcd_bus_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clk_en,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] value,
    output logic         expired
);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (clk_en) begin
            if (load) begin
                value <= load_value;
            end else if (value != '0) begin
                value <= value - W'(1);
            end
        end
    end

    assign expired = (value <= W'(1));

endmodule

// File: rtl/lcd_read_status.sv
// Nios II custom instruction performing HD44780 read cycles: busy flag/address
// (RS=0) or one data-RAM byte (RS=1), with optional busy-flag polling and timeout.
module lcd_read_status
    import lcd_pkg::*;
#(
    parameter int T_AS      = LCD_T_AS,
    parameter int T_PW      = LCD_T_PW,
    parameter int T_H       = LCD_T_H,
    parameter int MAX_POLLS = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    input  logic [7:0]  lcd_data_in,
    output logic [31:0] result,
    output logic        done,
    output logic        lcd_enable,
    output logic        lcd_rs,
    output logic        lcd_rw
);

    localparam int TW = $clog2(max3(T_AS, T_PW, T_H) + 1);
    localparam int PW = $clog2(MAX_POLLS + 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(MAX_POLLS - 1);

    logic [2:0]    state;
    logic          poll_q;
    logic [PW-1:0] poll_cnt;
    logic [7:0]    rd_byte;
    logic          timeout;
    logic          poll_again;

    logic          tmr_load;
    logic [TW-1:0] tmr_value_in;
    logic [TW-1:0] tmr_value;
    logic          tmr_expired;

    logic unused_inputs;
    assign unused_inputs = ^{datab, dataa[31:2], tmr_value};

    lcd_bus_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .load       (tmr_load),
        .load_value (tmr_value_in),
        .value      (tmr_value),
        .expired    (tmr_expired)
    );

    assign poll_again = poll_q && rd_byte[LCD_BUSY_BIT] && (poll_cnt < POLL_LAST);

    always_comb begin
        tmr_load     = 1'b0;
        tmr_value_in = '0;
        case (state)
            ST_IDLE:    if (start)       begin tmr_load = 1'b1; tmr_value_in = TW'(T_AS); end
            ST_SETUP:   if (tmr_expired) begin tmr_load = 1'b1; tmr_value_in = TW'(T_PW); end
            ST_EN_HIGH: if (tmr_expired) begin tmr_load = 1'b1; tmr_value_in = TW'(T_H);  end
            ST_CHECK:   if (poll_again)  begin tmr_load = 1'b1; tmr_value_in = TW'(T_AS); end
            default: ;
        endcase
    end

    always_comb begin
        result                     = '0;
        result[RESULT_TIMEOUT_BIT] = timeout;
        result[7:0]                = rd_byte;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            poll_q     <= 1'b0;
            poll_cnt   <= '0;
            rd_byte    <= '0;
            timeout    <= 1'b0;
            done       <= 1'b0;
            lcd_enable <= 1'b0;
            lcd_rs     <= 1'b0;
            lcd_rw     <= 1'b0;
        end else if (clk_en) begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        poll_q   <= dataa[CMD_POLL_BIT] & ~dataa[CMD_RS_BIT];
                        poll_cnt <= '0;
                        lcd_rs   <= dataa[CMD_RS_BIT];
                        lcd_rw   <= 1'b1;
                        timeout  <= 1'b0;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tmr_expired) begin
                        lcd_enable <= 1'b1;
                        state      <= ST_EN_HIGH;
                    end
                end
                ST_EN_HIGH: begin
                    if (tmr_expired) begin
                        rd_byte    <= lcd_data_in;
                        lcd_enable <= 1'b0;
                        state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (tmr_expired) state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (poll_again) begin
                        poll_cnt <= poll_cnt + PW'(1);
                        state    <= ST_SETUP;
                    end else begin
                        // Still busy here only when the poll budget ran out.
                        timeout <= poll_q && rd_byte[LCD_BUSY_BIT];
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    lcd_rw <= 1'b0;
                    lcd_rs <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_read_status.sv
// Self-checking bench for lcd_read_status: directed cases plus random commands
// and pin sequences, checked against a transaction-level timing/result model.
module tb_lcd_read_status;

    localparam int T_AS      = 2;
    localparam int T_PW      = 12;
    localparam int T_H       = 2;
    localparam int MAX_POLLS = 4;
    localparam int STALL     = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_en = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dataa = '0;
    logic [31:0] datab = '0;
    logic [7:0]  lcd_data_in = '0;
    logic [31:0] result;
    logic        done;
    logic        lcd_enable;
    logic        lcd_rs;
    logic        lcd_rw;

    logic [7:0] pins [8];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    lcd_read_status #(
        .T_AS(T_AS), .T_PW(T_PW), .T_H(T_H), .MAX_POLLS(MAX_POLLS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_en      (clk_en),
        .start       (start),
        .dataa       (dataa),
        .datab       (datab),
        .lcd_data_in (lcd_data_in),
        .result      (result),
        .done        (done),
        .lcd_enable  (lcd_enable),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic fill_pins(input logic [7:0] v);
        for (int i = 0; i < 8; i++) pins[i] = v;
    endtask

    // One transaction; stall_at > 0 drops clk_en for STALL cycles from that
    // cycle and pulses stray starts while the block is busy.
    task automatic do_txn(input logic [31:0] cmd, input int stall_at, input string tag);
        logic        exp_rs, poll, tmo, prev_en, bus_ok, idle_ok;
        logic [31:0] exp_res, res_at_done;
        int reads, exp_done, exp_en, pulses, en_len, done_cnt, done_cyc, cyc, extra;

        exp_rs = cmd[0];
        poll   = cmd[1] & ~cmd[0];
        reads  = 1;
        while (poll && reads < MAX_POLLS && pins[reads-1][7]) reads++;
        tmo      = poll && pins[reads-1][7];
        exp_res  = {tmo, 23'b0, pins[reads-1]};
        extra    = (stall_at > 0) ? STALL : 0;
        exp_done = (T_AS + T_PW + T_H + 2) + (reads - 1) * (T_AS + T_PW + T_H + 1) + extra;
        exp_en   = reads * T_PW + extra;

        pulses = 0; en_len = 0; done_cnt = 0; done_cyc = -1; cyc = 0;
        prev_en = 1'b0; bus_ok = 1'b1; idle_ok = 1'b1; res_at_done = '0;

        @(negedge clk);
        dataa = cmd; datab = $urandom; start = 1'b1;
        lcd_data_in = 8'($urandom);
        while (cyc < 400 && (done_cyc < 0 || cyc < done_cyc + 4)) begin
            @(negedge clk);
            cyc++;
            start = (stall_at > 0) && (cyc == stall_at + 2 || cyc == stall_at + 8);
            dataa = $urandom;
            datab = $urandom;
            if (stall_at > 0) clk_en = !(cyc >= stall_at && cyc < stall_at + STALL);
            if (lcd_enable && !prev_en) begin
                pulses++;
                lcd_data_in = pins[(pulses <= 8) ? pulses - 1 : 7];
            end
            prev_en = lcd_enable;
            if (lcd_enable) en_len++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc    = cyc;
                    res_at_done = result;
                end
            end
            if (done_cyc < 0 || cyc == done_cyc) begin
                if (lcd_rw !== 1'b1 || lcd_rs !== exp_rs) bus_ok = 1'b0;
            end else if (lcd_rw !== 1'b0 || lcd_rs !== 1'b0 || lcd_enable !== 1'b0) begin
                idle_ok = 1'b0;
            end
        end
        start  = 1'b0;
        clk_en = 1'b1;

        check({tag, " pulses"},   32'(pulses),   32'(reads));
        check({tag, " en_len"},   32'(en_len),   32'(exp_en));
        check({tag, " done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, " done_cyc"}, 32'(done_cyc), 32'(exp_done));
        check({tag, " result"},   res_at_done,   exp_res);
        check({tag, " bus"},      32'(bus_ok),   32'd1);
        check({tag, " idle"},     32'(idle_ok),  32'd1);
    endtask

    initial begin
        int seen;
        logic [31:0] cmd;
        int nbusy;

        repeat (3) @(negedge clk);
        check("reset outputs", {result[31:8], result[7:0], done, lcd_enable, lcd_rs, lcd_rw},
              '0);
        reset = 1'b0;
        @(negedge clk);

        fill_pins(8'h25); do_txn(32'h0, 0, "status");
        fill_pins(8'hC3); do_txn(32'h1, 0, "data");
        fill_pins(8'hC3); do_txn(32'h3, 0, "data_pollbit");
        fill_pins(8'h80); pins[3] = 8'h07; for (int i = 4; i < 8; i++) pins[i] = 8'h07;
        do_txn(32'h2, 0, "poll");
        fill_pins(8'h8A); do_txn(32'h2, 0, "timeout");
        fill_pins(8'h5A); do_txn(32'h0, 6, "stall");

        // Reset in the middle of EN_HIGH
        fill_pins(8'h3C);
        @(negedge clk); dataa = 32'h1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre-reset enable", 32'(lcd_enable), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid reset outputs", {result[31:8], result[7:0], done, lcd_enable, lcd_rs, lcd_rw},
              '0);
        reset = 1'b0;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done || lcd_rw || lcd_enable) seen++;
        end
        check("no done after reset", 32'(seen), 32'd0);
        fill_pins(8'h6E); do_txn(32'h0, 0, "after_reset");

        // Reset and start together: start is dropped
        @(negedge clk); reset = 1'b1; start = 1'b1; dataa = 32'h0;
        @(negedge clk); reset = 1'b0; start = 1'b0;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done || lcd_rw || lcd_enable) seen++;
        end
        check("reset beats start", 32'(seen), 32'd0);

        for (int t = 0; t < 12; t++) begin
            cmd   = $urandom;
            nbusy = $urandom_range(0, 5);
            for (int i = 0; i < 8; i++)
                pins[i] = 8'($urandom) | ((i < nbusy) ? 8'h80 : 8'h00);
            do_txn(cmd, 0, $sformatf("rand%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
